ifetch_unit: RTL and testbench
==============================

Name: ifetch_unit

Overview:
- Instruction-fetch stage directly downstream of the PC register. It consumes the current PC, issues instruction-memory requests and drives the PC register's write enable so that the PC advances only when a fetch is accepted.
- Returned instructions are buffered with their PCs in a small in-order queue and presented to decode over a valid/ready handshake.
- Handles decode backpressure and pipeline flush (branch/jump redirect), including discarding responses already in flight.

Parameters:
- WORD_LEN, 32, instruction width.
- ADDR_SIZE, 32, address width.
- DEPTH, 2, fetch-queue entries; also the maximum number of outstanding requests. Must be a power of 2, at least 2.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on the rising edge of clk).
- pc_in  input  ADDR_SIZE  current PC, from the PC register's read data.
- pc_en  output  1  PC register write enable; the next-PC mux selects PC+4, or the redirect target when flush=1.
- flush  input  1  redirect from execute; the PC register loads the target in the same cycle.
- imem_req_valid  output  1  request valid.
- imem_req_addr  output  ADDR_SIZE  request address, equal to pc_in.
- imem_req_ready  input  1  memory accepts the request.
- imem_rsp_valid  input  1  response valid; in-order, one per accepted request, no backpressure.
- imem_rsp_data  input  WORD_LEN  instruction word.
- id_valid  output  1  instruction available to decode.
- id_instr  output  WORD_LEN  instruction at the queue head.
- id_pc  output  ADDR_SIZE  PC of the queue head.
- id_ready  input  1  decode consumes the head.

Behaviour:
- Reset (reset=0 at edge):
  - state=RUN; queue empty; outstanding=0; drop=0.
  - Outputs: imem_req_valid=0, id_valid=0, pc_en=0, id_instr=0, id_pc=0.
  - A mid-operation reset abandons all entries and in-flight tracking immediately; the memory is expected to be reset by the same signal.
- Credit:
  - issue_ok = (count + outstanding < DEPTH) and state==RUN and flush==0.
  - imem_req_valid = issue_ok (combinational).
  - A handshake (valid & ready) increments outstanding and records pc_in in a PC shadow queue at the tail.
- PC advance: pc_en = (imem_req_valid & imem_req_ready) | flush. There is never a double advance because a request is suppressed when flush=1.
- Response, state RUN, drop==0:
  - Write {pc_shadow_head, imem_rsp_data} to the queue tail.
  - outstanding decrements; count increments.
- Dequeue: id_valid = (count != 0); id_instr and id_pc come from the head. id_valid & id_ready pops the head.
- Same-cycle push and pop: count is unchanged, and both pointers advance modulo DEPTH.
- Flush:
  - Queue emptied at the next edge; a same-cycle id_ready pop is ignored; id_valid=0 in the following cycle.
  - drop <= outstanding minus (1 if a response arrives in that same cycle).
  - outstanding <= drop value; the PC shadow queue is cleared.
  - If the new drop > 0, go to DRAIN; otherwise stay in RUN.
- DRAIN:
  - No requests are issued.
  - Each response decrements drop and outstanding and is discarded.
  - When drop reaches 1 and a response arrives, go to RUN; issue resumes in the next cycle with the redirected pc_in.
- Flush in DRAIN: drop is recomputed as above and the state stays in DRAIN. Flush is idempotent.
- A response while outstanding==0 is a protocol error: ignored, with a simulation assertion.
- Latency:
  - Best case, request accepted in cycle N and response in cycle N+1: id_valid=1 in cycle N+2.
  - Decode always receives instructions in program order with the correct PC.
- Pointers: $clog2(DEPTH) bits, wrap naturally. count and outstanding are $clog2(DEPTH)+1 bits.

Decomposition:
- Shared defines header: WORD_LEN, ADDR_SIZE, RESET_PC, fetch-state encodings (RUN, DRAIN).
- One sub-module, fetch_fifo: a parameterised DEPTH×(ADDR_SIZE+WORD_LEN) circular buffer with push/pop/clear and count. It is instantiated twice: once for the PC shadow queue (PC only) and once for the fetch queue.
- FSM, credit logic and pc_en generation live in ifetch_unit.

Test Plan:
- Reset: hold reset=0 for 3 cycles with pc_in=0x80000000 -> imem_req_valid=0, pc_en=0, id_valid=0. Release -> next cycle imem_req_valid=1, imem_req_addr=0x80000000.
- Streaming: memory always ready with 1-cycle response, id_ready=1, PC register connected -> id_pc sequence 0x80000000, 0x80000004, 0x80000008 …, one per cycle after a 2-cycle fill; instructions match memory contents.
- Backpressure: hold id_ready=0 for 5 cycles -> at most 2 requests issued; then imem_req_valid=0 and pc_en=0; id_pc is held at 0x80000000. Release -> order preserved with no loss.
- Memory stall: imem_req_ready=0 for 4 cycles -> pc_en=0 and imem_req_addr constant throughout; the PC does not advance.
- Flush with 2 in flight: flush=1 and target 0x80000100 while outstanding=2 -> DRAIN. The next 2 responses are dropped and id_valid stays 0. First new request address is 0x80000100; the first id_pc after the flush is 0x80000100.
- Simultaneous flush and response, outstanding=1 -> drop=0, state stays RUN, the response is discarded, and issue to the target occurs in the next cycle.

Source files
------------

// File: rtl/ifetch_unit_pkg.sv
// Shared widths, reset PC and fetch-state encodings for the instruction-fetch stage.
package ifetch_unit_pkg;

   localparam int WORD_LEN  = 32;
   localparam int ADDR_SIZE = 32;
   localparam logic [ADDR_SIZE-1:0] RESET_PC = 32'h8000_0000;

   typedef enum logic {
      RUN   = 1'b0,
      DRAIN = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/ifetch_unit_if.sv
// Fetch-stage bus: PC register hookup, imem request/response and decode handshake.
interface ifetch_unit_if #(
   parameter int WORD_LEN  = ifetch_unit_pkg::WORD_LEN,
   parameter int ADDR_SIZE = ifetch_unit_pkg::ADDR_SIZE
);
   logic [ADDR_SIZE-1:0] pc_in;
   logic                 pc_en;
   logic                 flush;
   logic                 imem_req_valid;
   logic [ADDR_SIZE-1:0] imem_req_addr;
   logic                 imem_req_ready;
   logic                 imem_rsp_valid;
   logic [WORD_LEN-1:0]  imem_rsp_data;
   logic                 id_valid;
   logic [WORD_LEN-1:0]  id_instr;
   logic [ADDR_SIZE-1:0] id_pc;
   logic                 id_ready;

   modport master (
      input  pc_in, flush, imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready,
      output pc_en, imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc
   );

   modport slave (
      output pc_in, flush, imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready,
      input  pc_en, imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc
   );
endinterface

// File: rtl/ifetch_unit_fetch_fifo.sv
// Circular buffer with push/pop/clear and occupancy count; head reads as zero when empty.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: none internally; the caller must never push when full.
module ifetch_unit_fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 64
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   clear,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_data,
   input  logic                   pop,
   output logic [WIDTH-1:0]       pop_data,
   output logic [$clog2(DEPTH):0] count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_pop;

   assign do_pop   = pop && (count != '0);
   assign pop_data = (count != '0) ? mem[rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (!reset || clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(push) - CW'(do_pop);
      end
   end
endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch: credit-limited imem requests, PC advance, in-order queue to decode.
// Latency: request accepted in cycle N, response in N+1, id_valid in N+2.
// Backpressure: id_ready low fills the queue, which withholds credit and stalls the PC.
module ifetch_unit #(
   parameter int WORD_LEN  = 32,
   parameter int ADDR_SIZE = 32,
   parameter int DEPTH     = 2
) (
   input  logic          clk,
   input  logic          reset,
   ifetch_unit_if.master bus
);
   import ifetch_unit_pkg::*;

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

   typedef struct packed {
      logic [ADDR_SIZE-1:0] pc;
      logic [WORD_LEN-1:0]  instr;
   } fetch_entry_t;

   fetch_state_t         state;
   logic [CW-1:0]        count, outstanding, drop, shadow_count, out_after_rsp;
   logic [CW:0]          in_use;
   logic [ADDR_SIZE-1:0] shadow_pc;
   fetch_entry_t         head, tail;
   logic                 issue_ok, req_fire, rsp_ok, rsp_take, pop;

   assign in_use        = {1'b0, count} + {1'b0, outstanding};
   assign issue_ok      = reset && (state == RUN) && !bus.flush && (in_use < DEPTH_C);
   assign req_fire      = issue_ok && bus.imem_req_ready;
   // A response with nothing outstanding is a protocol violation and is ignored.
   assign rsp_ok        = bus.imem_rsp_valid && (outstanding != '0);
   assign rsp_take      = rsp_ok && (state == RUN) && !bus.flush;
   assign pop           = bus.id_valid && bus.id_ready && !bus.flush;
   assign out_after_rsp = outstanding - CW'(rsp_ok);
   assign tail          = '{pc: shadow_pc, instr: bus.imem_rsp_data};

   assign bus.imem_req_valid = issue_ok;
   assign bus.imem_req_addr  = bus.pc_in;
   assign bus.pc_en          = req_fire || (reset && bus.flush);
   assign bus.id_valid       = (count != '0);
   assign bus.id_instr       = head.instr;
   assign bus.id_pc          = head.pc;

   ifetch_unit_fetch_fifo #(.DEPTH(DEPTH), .WIDTH(ADDR_SIZE)) u_pc_shadow (
      .clk       (clk),
      .reset     (reset),
      .clear     (bus.flush),
      .push      (req_fire),
      .push_data (bus.pc_in),
      .pop       (rsp_ok && (state == RUN)),
      .pop_data  (shadow_pc),
      .count     (shadow_count)
   );

   ifetch_unit_fetch_fifo #(.DEPTH(DEPTH), .WIDTH(ADDR_SIZE + WORD_LEN)) u_fetch_q (
      .clk       (clk),
      .reset     (reset),
      .clear     (bus.flush),
      .push      (rsp_take),
      .push_data (tail),
      .pop       (pop),
      .pop_data  (head),
      .count     (count)
   );

   // After a flush every request still in flight belongs to the old path and is dropped.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= RUN;
         outstanding <= '0;
         drop        <= '0;
      end else begin
         outstanding <= out_after_rsp + CW'(req_fire);
         if (bus.flush) begin
            drop  <= out_after_rsp;
            state <= (out_after_rsp != '0) ? DRAIN : RUN;
         end else if (state == DRAIN && rsp_ok) begin
            drop <= drop - 1'b1;
            if (drop == CW'(1))
               state <= RUN;
         end
      end
   end

   a_rsp_credit: assert property (@(posedge clk) disable iff (!reset)
      !(bus.imem_rsp_valid && outstanding == '0))
      else $error("imem response with no request outstanding");

   a_shadow_sync: assert property (@(posedge clk) disable iff (!reset)
      (state == RUN) |-> (shadow_count == outstanding))
      else $error("pc shadow queue out of step with outstanding count");
endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit with a PC register and a 1-cycle imem model.
module tb_ifetch_unit;
   import ifetch_unit_pkg::*;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   ifetch_unit_if #(.WORD_LEN(32), .ADDR_SIZE(32)) bus ();

   ifetch_unit #(.WORD_LEN(32), .ADDR_SIZE(32), .DEPTH(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] pc_reg;
   logic [31:0] target;
   logic        rsp_en;
   logic [31:0] pend[$];
   logic [31:0] got_pc[$];
   logic [31:0] got_ins[$];
   logic [31:0] iss[$];

   assign bus.pc_in = pc_reg;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return a ^ 32'hDEAD_BEEF;
   endfunction

   always @(posedge clk) begin : pc_register
      if (!reset)
         pc_reg <= RESET_PC;
      else if (bus.pc_en)
         pc_reg <= bus.flush ? target : pc_reg + 32'd4;
   end

   // Responses come back in order, one cycle after acceptance while rsp_en is high.
   always @(posedge clk) begin : imem_model
      if (!reset) begin
         pend.delete();
         bus.imem_rsp_valid <= 1'b0;
         bus.imem_rsp_data  <= '0;
      end else begin
         if (bus.imem_rsp_valid)
            void'(pend.pop_front());
         if (bus.imem_req_valid && bus.imem_req_ready)
            pend.push_back(bus.imem_req_addr);
         if (rsp_en && pend.size() > 0) begin
            bus.imem_rsp_valid <= 1'b1;
            bus.imem_rsp_data  <= instr_of(pend[0]);
         end else begin
            bus.imem_rsp_valid <= 1'b0;
         end
      end
   end

   always @(posedge clk) begin : monitor
      if (reset) begin
         if (bus.id_valid && bus.id_ready && !bus.flush) begin
            got_pc.push_back(bus.id_pc);
            got_ins.push_back(bus.id_instr);
         end
         if (bus.imem_req_valid && bus.imem_req_ready)
            iss.push_back(bus.imem_req_addr);
      end
   end

   task automatic do_reset(input logic rdy, input logic idr, input logic ren);
      reset = 1'b0;
      bus.flush = 1'b0;
      target = '0;
      bus.imem_req_ready = rdy;
      bus.id_ready = idr;
      rsp_en = ren;
      repeat (2) @(negedge clk);
      got_pc.delete();
      got_ins.delete();
      iss.delete();
      reset = 1'b1;
      #1;
   endtask

   task automatic wait_got(input int n);
      for (int i = 0; i < 40 && got_pc.size() < n; i++) @(negedge clk);
      #1;
      n_tests++; if (got_pc.size() < n) begin n_fail++; $display("FAIL wait_got: got %0d instrs, need %0d", got_pc.size(), n); end
   endtask

   task automatic check_seq(input string name, input logic [31:0] base, input int n);
      for (int k = 0; k < n; k++) begin
         if (got_pc.size() > k) begin
            n_tests++; if (got_pc[k] !== base + 32'(4*k)) begin n_fail++; $display("FAIL %s_pc[%0d]: got %h want %h", name, k, got_pc[k], base + 32'(4*k)); end
            n_tests++; if (got_ins[k] !== instr_of(base + 32'(4*k))) begin n_fail++; $display("FAIL %s_instr[%0d]: got %h want %h", name, k, got_ins[k], instr_of(base + 32'(4*k))); end
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; bus.flush = 1'b0; target = '0;
      bus.imem_req_ready = 1'b1; bus.id_ready = 1'b1; rsp_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         n_tests++; if (bus.imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid c%0d: got %b want 0", i, bus.imem_req_valid); end
         n_tests++; if (bus.pc_en !== 1'b0) begin n_fail++; $display("FAIL reset_pc_en c%0d: got %b want 0", i, bus.pc_en); end
         n_tests++; if (bus.id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_id_valid c%0d: got %b want 0", i, bus.id_valid); end
      end
      n_tests++; if (bus.id_instr !== 32'h0) begin n_fail++; $display("FAIL reset_id_instr: got %h want 0", bus.id_instr); end
      n_tests++; if (bus.id_pc !== 32'h0) begin n_fail++; $display("FAIL reset_id_pc: got %h want 0", bus.id_pc); end
      bus.imem_req_ready = 1'b0;
      reset = 1'b1;
      #1;
      n_tests++; if (bus.imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL release_req_valid: got %b want 1", bus.imem_req_valid); end
      n_tests++; if (bus.imem_req_addr !== 32'h8000_0000) begin n_fail++; $display("FAIL release_req_addr: got %h want 80000000", bus.imem_req_addr); end
      n_tests++; if (bus.pc_en !== 1'b0) begin n_fail++; $display("FAIL release_pc_en_not_ready: got %b want 0", bus.pc_en); end
   endtask

   task automatic test_stream();
      do_reset(1'b1, 1'b1, 1'b1);
      n_tests++; if (bus.imem_req_valid !== 1'b1 || bus.pc_en !== 1'b1) begin n_fail++; $display("FAIL stream_first_issue: valid %b pc_en %b want 1 1", bus.imem_req_valid, bus.pc_en); end
      @(negedge clk); #1;
      n_tests++; if (bus.id_valid !== 1'b0) begin n_fail++; $display("FAIL stream_n1_id_valid: got %b want 0", bus.id_valid); end
      @(negedge clk); #1;
      n_tests++; if (bus.id_valid !== 1'b1) begin n_fail++; $display("FAIL stream_n2_id_valid: got %b want 1", bus.id_valid); end
      n_tests++; if (bus.id_pc !== 32'h8000_0000) begin n_fail++; $display("FAIL stream_n2_id_pc: got %h want 80000000", bus.id_pc); end
      wait_got(8);
      check_seq("stream", 32'h8000_0000, 8);
   endtask

   task automatic test_backpressure();
      do_reset(1'b1, 1'b0, 1'b1);
      repeat (5) @(negedge clk);
      #1;
      n_tests++; if (iss.size() != 2) begin n_fail++; $display("FAIL bp_issued: got %0d want 2", iss.size()); end
      n_tests++; if (bus.imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL bp_req_valid: got %b want 0", bus.imem_req_valid); end
      n_tests++; if (bus.pc_en !== 1'b0) begin n_fail++; $display("FAIL bp_pc_en: got %b want 0", bus.pc_en); end
      n_tests++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h8000_0000) begin n_fail++; $display("FAIL bp_head: valid %b pc %h want 1 80000000", bus.id_valid, bus.id_pc); end
      bus.id_ready = 1'b1;
      wait_got(6);
      check_seq("bp", 32'h8000_0000, 6);
   endtask

   task automatic test_mem_stall();
      do_reset(1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) begin
         n_tests++; if (bus.pc_en !== 1'b0) begin n_fail++; $display("FAIL stall_pc_en c%0d: got %b want 0", i, bus.pc_en); end
         n_tests++; if (bus.imem_req_addr !== 32'h8000_0000) begin n_fail++; $display("FAIL stall_addr c%0d: got %h want 80000000", i, bus.imem_req_addr); end
         @(negedge clk); #1;
      end
      n_tests++; if (iss.size() != 0) begin n_fail++; $display("FAIL stall_issued: got %0d want 0", iss.size()); end
      bus.imem_req_ready = 1'b1;
      wait_got(3);
      check_seq("stall", 32'h8000_0000, 3);
   endtask

   task automatic test_flush_drain();
      do_reset(1'b1, 1'b1, 1'b0);
      @(negedge clk); #1;
      @(negedge clk); #1;
      n_tests++; if (bus.imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL fd_credit_full: got %b want 0", bus.imem_req_valid); end
      bus.flush = 1'b1;
      target = 32'h8000_0100;
      #1;
      n_tests++; if (bus.pc_en !== 1'b1) begin n_fail++; $display("FAIL fd_flush_pc_en: got %b want 1", bus.pc_en); end
      @(negedge clk); #1;
      bus.flush = 1'b0;
      rsp_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_tests++; if (bus.imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL fd_drain_req c%0d: got %b want 0", i, bus.imem_req_valid); end
         n_tests++; if (bus.id_valid !== 1'b0) begin n_fail++; $display("FAIL fd_drain_id_valid c%0d: got %b want 0", i, bus.id_valid); end
         @(negedge clk);
      end
      #1;
      n_tests++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h8000_0100) begin n_fail++; $display("FAIL fd_resume: valid %b addr %h want 1 80000100", bus.imem_req_valid, bus.imem_req_addr); end
      wait_got(3);
      check_seq("fd", 32'h8000_0100, 3);
   endtask

   task automatic test_flush_rsp();
      do_reset(1'b1, 1'b1, 1'b1);
      @(negedge clk); #1;
      bus.flush = 1'b1;
      target = 32'h8000_0200;
      #1;
      n_tests++; if (bus.imem_req_valid !== 1'b0 || bus.pc_en !== 1'b1) begin n_fail++; $display("FAIL fr_flush: valid %b pc_en %b want 0 1", bus.imem_req_valid, bus.pc_en); end
      @(negedge clk); #1;
      bus.flush = 1'b0;
      #1;
      n_tests++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h8000_0200) begin n_fail++; $display("FAIL fr_issue: valid %b addr %h want 1 80000200", bus.imem_req_valid, bus.imem_req_addr); end
      n_tests++; if (bus.id_valid !== 1'b0) begin n_fail++; $display("FAIL fr_discard: id_valid %b want 0", bus.id_valid); end
      wait_got(2);
      check_seq("fr", 32'h8000_0200, 2);
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_mem_stall();
      test_flush_drain();
      test_flush_rsp();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
